// File: rtl/field_unpack.sv
// field_unpack: splits a packed word into MSB-first fields, one zero-extended field per beat.
// Defining FIELD_UNPACK_SEXT_EN adds in_sext, which sign-extends each field instead.
module field_unpack #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int NUM_FIELDS = 4,
    parameter int LEN_W      = $clog2(OUT_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic [NUM_FIELDS*LEN_W-1:0] in_lens,
`ifdef FIELD_UNPACK_SEXT_EN
    input  logic                        in_sext,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [LEN_W-1:0]            out_len,
    output logic                        out_last,
    output logic                        err
);
    localparam int SUM_W = $clog2(IN_WIDTH + 1) + 1;
    localparam int IDX_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic {IDLE, EMIT} stateT;

    stateT                       state;
    logic [IN_WIDTH-1:0]         sr, srcSr;
    logic [NUM_FIELDS*LEN_W-1:0] lens, srcLens;
    logic [IDX_W-1:0]            idx, nIdx;
    logic [IDX_W:0]              fromIdx;
    logic [LEN_W-1:0]            curLen, nLen;
    logic [SUM_W-1:0]            sum, shamt;
    logic [OUT_WIDTH-1:0]        field, nData;
    logic                        sext, sextIn, srcSext, found, more, tooLong, bad;

`ifdef FIELD_UNPACK_SEXT_EN
    assign sextIn = in_sext;
`else
    assign sextIn = 1'b0;
`endif

    assign in_ready = state == IDLE;

    // One lookup serves both the accept (from the incoming word) and the advance (from the shifted sr).
    always_comb begin
        curLen  = lens[idx*LEN_W +: LEN_W];
        srcSr   = state == IDLE ? in_data : sr << curLen;
        srcLens = state == IDLE ? in_lens : lens;
        srcSext = state == IDLE ? sextIn : sext;
        fromIdx = state == IDLE ? '0 : {1'b0, idx} + 1'b1;
        found   = 1'b0;
        nIdx    = '0;
        more    = 1'b0;
        sum     = '0;
        tooLong = 1'b0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (i >= int'(fromIdx) && srcLens[i*LEN_W +: LEN_W] != '0) begin
                found = 1'b1;
                nIdx  = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (i > int'(nIdx) && srcLens[i*LEN_W +: LEN_W] != '0) more = 1'b1;
            if (int'(srcLens[i*LEN_W +: LEN_W]) > OUT_WIDTH) tooLong = 1'b1;
            sum = sum + SUM_W'(srcLens[i*LEN_W +: LEN_W]);
        end
        nLen  = srcLens[nIdx*LEN_W +: LEN_W];
        shamt = SUM_W'(IN_WIDTH) - SUM_W'(nLen);
        field = OUT_WIDTH'(srcSr >> shamt);
        nData = (srcSext && nLen != '0 && srcSr[IN_WIDTH-1]) ? field | ({OUT_WIDTH{1'b1}} << nLen) : field;
        bad   = tooLong || sum > SUM_W'(IN_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            lens      <= '0;
            idx       <= '0;
            sext      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    sr   <= in_data;
                    lens <= in_lens;
                    sext <= sextIn;
                    if (bad) err <= 1'b1;
                    else if (found) begin
                        state     <= EMIT;
                        idx       <= nIdx;
                        out_valid <= 1'b1;
                        out_data  <= nData;
                        out_len   <= nLen;
                        out_last  <= !more;
                    end
                end
            end else if (out_ready) begin
                sr <= srcSr;
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    idx      <= nIdx;
                    out_data <= nData;
                    out_len  <= nLen;
                    out_last <= !more;
                end
            end
        end
    end
endmodule
